// File: rtl/serial_frame_packer.sv
// Packs one read request's serialized payload bytes into a framed stream:
// SOF, length, payload, XOR checksum, over a registered valid/ready output.
module serial_frame_packer #(
  parameter int         DEPTH    = 16,
  parameter logic [7:0] SOF_BYTE = 8'hA5
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       i_frame_start,
  input  logic [5:0] i_RCC_BUFFER_LENGTH,
  input  logic [7:0] i_serialized_output,
  input  logic       i_serialized_output_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  input  logic       i_byte_ready,
  output logic       o_frame_done,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_LENB, S_PAYLOAD, S_CSUM
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    rx_count_q, rx_count_d;
  logic [7:0]    tx_count_q, tx_count_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    obyte_q, obyte_d;
  logic          ovalid_q, ovalid_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [7:0]    mem_q [DEPTH];

  logic          xfer, pop, capturing, push_req, push, abort;
  logic [AW:0]   cnt_after_pop;
  logic [7:0]    head;
  logic          head_avail;

  // Fullness is judged after this cycle's pop, so a push alongside a pop
  // into a full buffer is legal.
  always_comb begin
    xfer          = ovalid_q & i_byte_ready;
    pop           = xfer && (state_q == S_PAYLOAD);
    cnt_after_pop = count_q - (AW+1)'(pop);
    capturing     = (state_q == S_SOF) || (state_q == S_LENB) || (state_q == S_PAYLOAD);
    push_req      = i_serialized_output_valid && capturing && (rx_count_q < len_q);
    push          = push_req && (cnt_after_pop != FULL_CNT);
    abort         = push_req && !push;
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    // An empty buffer being written this cycle forwards the incoming byte.
    head_avail    = (cnt_after_pop != '0) || push;
    head          = (cnt_after_pop != '0) ? mem_q[rd_ptr_d] : i_serialized_output;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = cnt_after_pop + (AW+1)'(push);
    len_d      = len_q;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    csum_d     = csum_q;
    obyte_d    = obyte_q;
    ovalid_d   = ovalid_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          state_d    = S_SOF;
          len_d      = {i_RCC_BUFFER_LENGTH, 2'b00};
          rx_count_d = '0;
          tx_count_d = '0;
          csum_d     = '0;
        end
      end
      S_SOF: begin
        if (xfer) begin
          state_d  = S_LENB;
          ovalid_d = 1'b0;
        end else if (!ovalid_q) begin
          obyte_d  = SOF_BYTE;
          ovalid_d = 1'b1;
        end
      end
      S_LENB: begin
        if (xfer) begin
          csum_d   = len_q;
          state_d  = (len_q == '0) ? S_CSUM : S_PAYLOAD;
          ovalid_d = 1'b0;
        end else if (!ovalid_q) begin
          obyte_d  = len_q;
          ovalid_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (xfer || !ovalid_q) begin
          if (pop) begin
            tx_count_d = tx_count_q + 8'd1;
            csum_d     = csum_q ^ obyte_q;
          end
          if (tx_count_d == len_q) begin
            state_d  = S_CSUM;
            ovalid_d = 1'b0;
          end else if (head_avail) begin
            obyte_d  = head;
            ovalid_d = 1'b1;
          end else begin
            ovalid_d = 1'b0;
          end
        end
      end
      S_CSUM: begin
        if (xfer) begin
          done_d   = 1'b1;
          state_d  = S_IDLE;
          ovalid_d = 1'b0;
        end else if (!ovalid_q) begin
          obyte_d  = csum_q;
          ovalid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      rx_count_d = rx_count_q + 8'd1;
    end

    // Overflow drops the byte, flushes the buffer and abandons the frame.
    if (abort) begin
      state_d  = S_IDLE;
      ovalid_d = 1'b0;
      done_d   = 1'b0;
      ovf_d    = 1'b1;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      len_q      <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      csum_q     <= '0;
      obyte_q    <= '0;
      ovalid_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= abort ? '0 : rd_ptr_d;
      count_q    <= count_d;
      len_q      <= len_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      csum_q     <= csum_d;
      obyte_q    <= obyte_d;
      ovalid_q   <= ovalid_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= i_serialized_output;
  end

  assign o_byte       = obyte_q;
  assign o_byte_valid = ovalid_q;
  assign o_frame_done = done_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule
